// File: rtl/pend_priority_encoder.sv
// rtl/pend_priority_encoder.sv - sticky-request priority encoder with a valid/ready output slot
// Optional sticky overflow flag enabled by defining PENC_OVF_EN.
module pend_priority_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         none,
  output logic         ovf
);

  logic [N-1:0] cand;
  logic [N-1:0] pop;
  logic [W-1:0] sel;
  logic         found;
  logic         load_en;

  assign cand    = pending & ~mask;
  assign load_en = !out_valid || out_ready;
  assign none    = !out_valid && (cand == '0);

  // Ascending scan so the last hit, the highest index, wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) begin
        sel   = W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load_en && found) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      // A request on the bit being popped re-arms it for a later service.
      pending <= (pending & ~pop) | req;
      if (load_en) begin
        if (found) begin
          out_idx   <= sel;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef PENC_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf_q <= 1'b0;
    end else if (|(req & pending & ~pop)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
